// File: rtl/satacrc_engine.sv
// satacrc_engine: SATA link-layer frame CRC engine, one dword per beat.
// OPT_RX=0 appends the frame CRC; OPT_RX=1 strips the trailing CRC dword and flags errors.
module satacrc_engine #(
    parameter logic [31:0] POLYNOMIAL   = 32'h04c1_1db7,
    parameter logic [31:0] INITIAL_CRC  = 32'h5232_5032,
    parameter bit          OPT_RX       = 1'b0,
    parameter bit          OPT_LOWPOWER = 1'b1
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        i_abort,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TLAST,
    output logic        M_AXIS_TUSER,
    output logic        o_crc_err,
    output logic        o_busy
);
    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_DATA  = 2'b01;
    localparam logic [1:0] S_CRC   = 2'b10;
    localparam logic [1:0] S_DRAIN = 2'b10;

    logic [1:0]  state, st;
    logic [31:0] crc, crc_next, hold, m_data;
    logic        m_valid, m_last, m_user, crc_err, out_free, accept;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r, dd;
        r  = c;
        dd = d;
        for (int k = 0; k < 32; k++) begin
            r  = {r[30:0], 1'b0} ^ ((r[31] ^ dd[31]) ? POLYNOMIAL : 32'h0);
            dd = {dd[30:0], 1'b0};
        end
        return r;
    endfunction

    // 2'b11 is unreachable but treated as idle so the engine can always recover
    assign st            = (state == 2'b11) ? S_IDLE : state;
    assign out_free      = !m_valid || M_AXIS_TREADY;
    assign S_AXIS_TREADY = S_AXI_ARESETN && !i_abort && (st != S_CRC) && out_free;
    assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;
    assign crc_next      = crc_step(crc, S_AXIS_TDATA);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state   <= S_IDLE;
            crc     <= INITIAL_CRC;
            hold    <= 32'h0;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_last  <= 1'b0;
            m_user  <= 1'b0;
            crc_err <= 1'b0;
        end else if (i_abort) begin
            state   <= S_IDLE;
            crc     <= INITIAL_CRC;
            hold    <= 32'h0;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_last  <= 1'b0;
            m_user  <= 1'b0;
            crc_err <= 1'b0;
        end else if (!OPT_RX) begin
            crc_err <= 1'b0;
            if (accept) begin
                m_valid <= 1'b1;
                m_data  <= S_AXIS_TDATA;
                m_last  <= 1'b0;
                m_user  <= 1'b0;
                crc     <= crc_next;
                state   <= S_AXIS_TLAST ? S_CRC : S_DATA;
            end else if (st == S_CRC && out_free) begin
                m_valid <= 1'b1;
                m_data  <= crc;
                m_last  <= 1'b1;
                m_user  <= 1'b0;
                crc     <= INITIAL_CRC;
                state   <= S_IDLE;
            end else if (M_AXIS_TREADY) begin
                m_valid <= 1'b0;
            end
        end else begin
            crc_err <= 1'b0;
            if (st == S_DRAIN)
                state <= S_IDLE;
            // the buffered dword only leaves once its successor (or the CRC) shows up
            if (accept && st == S_DATA) begin
                m_valid <= 1'b1;
                m_data  <= hold;
                m_last  <= S_AXIS_TLAST;
                m_user  <= S_AXIS_TLAST && (crc_next != 32'h0);
            end else if (M_AXIS_TREADY) begin
                m_valid <= 1'b0;
            end
            if (accept && S_AXIS_TLAST) begin
                crc     <= INITIAL_CRC;
                crc_err <= (st == S_IDLE) || (crc_next != 32'h0);
                state   <= (st == S_DATA) ? S_DRAIN : S_IDLE;
            end else if (accept) begin
                crc   <= crc_next;
                hold  <= S_AXIS_TDATA;
                state <= S_DATA;
            end
        end
    end

    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TDATA  = (OPT_LOWPOWER && !m_valid) ? 32'h0 : m_data;
    assign M_AXIS_TLAST  = (OPT_LOWPOWER && !m_valid) ? 1'b0 : m_last;
    assign M_AXIS_TUSER  = (OPT_LOWPOWER && !m_valid) ? 1'b0 : m_user;
    assign o_crc_err     = crc_err;
    assign o_busy        = (st != S_IDLE) || m_valid;
endmodule

// File: tb/tb_satacrc_engine.sv
// tb_satacrc_engine: drives a TX and an RX engine against a polynomial-division CRC model.
module tb_satacrc_engine;
    localparam logic [31:0] POLY = 32'h04c1_1db7;
    localparam logic [31:0] INIT = 32'h5232_5032;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        abort = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0, sel_rx = 1'b0;
    logic [31:0] s_data = 32'h0;
    logic        tx_sr, tx_mv, tx_ml, tx_mu, tx_err, tx_busy;
    logic        rx_sr, rx_mv, rx_ml, rx_mu, rx_err, rx_busy;
    logic [31:0] tx_md, rx_md;
    logic        cur_sr, cur_mv, cur_ml, cur_mu, cur_err, cur_busy;
    logic [31:0] cur_md;

    always #5 clk = ~clk;

    satacrc_engine #(.OPT_RX(1'b0)) u_tx (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_abort(abort && !sel_rx),
        .S_AXIS_TVALID(s_valid && !sel_rx), .S_AXIS_TREADY(tx_sr), .S_AXIS_TDATA(s_data),
        .S_AXIS_TLAST(s_last), .M_AXIS_TVALID(tx_mv), .M_AXIS_TREADY(m_ready),
        .M_AXIS_TDATA(tx_md), .M_AXIS_TLAST(tx_ml), .M_AXIS_TUSER(tx_mu),
        .o_crc_err(tx_err), .o_busy(tx_busy)
    );

    satacrc_engine #(.OPT_RX(1'b1)) u_rx (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_abort(abort && sel_rx),
        .S_AXIS_TVALID(s_valid && sel_rx), .S_AXIS_TREADY(rx_sr), .S_AXIS_TDATA(s_data),
        .S_AXIS_TLAST(s_last), .M_AXIS_TVALID(rx_mv), .M_AXIS_TREADY(m_ready),
        .M_AXIS_TDATA(rx_md), .M_AXIS_TLAST(rx_ml), .M_AXIS_TUSER(rx_mu),
        .o_crc_err(rx_err), .o_busy(rx_busy)
    );

    assign cur_sr   = sel_rx ? rx_sr : tx_sr;
    assign cur_mv   = sel_rx ? rx_mv : tx_mv;
    assign cur_md   = sel_rx ? rx_md : tx_md;
    assign cur_ml   = sel_rx ? rx_ml : tx_ml;
    assign cur_mu   = sel_rx ? rx_mu : tx_mu;
    assign cur_err  = sel_rx ? rx_err : tx_err;
    assign cur_busy = sel_rx ? rx_busy : tx_busy;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
    } beat_t;

    typedef struct {
        bit          rx;
        int          n;
        bit          bad;
        int          bp;
        logic [31:0] d0;
        logic [31:0] d1;
        int          beats;
        bit          err;
    } vec_t;

    int          errors = 0, checks = 0, cyc = 0, bp_mode = 0;
    int          err_cnt = 0, lp_viol = 0, stall_viol = 0;
    beat_t       q[$];
    beat_t       prev;
    logic        prev_stall = 1'b0;
    logic [31:0] frm[0:15];
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference CRC: long division of (frame * x^32 + seed * x^len) by x^32 + POLY
    function automatic logic [31:0] model_crc(input int n);
        bit          b[$];
        logic [31:0] w, pp, r;
        for (int i = 0; i < n; i++) begin
            w = frm[i];
            for (int k = 0; k < 32; k++) begin
                b.push_back(w[31]);
                w = w << 1;
            end
        end
        repeat (32) b.push_back(1'b0);
        w = INIT;
        for (int i = 0; i < 32; i++) begin
            b[i] ^= w[31];
            w = w << 1;
        end
        for (int i = 0; i + 32 < b.size(); i++) begin
            if (b[i]) begin
                pp = POLY;
                for (int j = 0; j < 32; j++) begin
                    b[i + 1 + j] ^= pp[31];
                    pp = pp << 1;
                end
            end
        end
        r = 32'h0;
        for (int j = 0; j < 32; j++) r = {r[30:0], b[b.size() - 32 + j]};
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0: m_ready = 1'b1;
            1: m_ready = ~m_ready;
            2: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (cur_mv && m_ready) q.push_back(beat_t'{cur_md, cur_ml, cur_mu});
            if (cur_err) err_cnt++;
            if (!cur_mv && (cur_md != 32'h0 || cur_ml || cur_mu)) lp_viol++;
            if (prev_stall && !(cur_mv && cur_md == prev.d && cur_ml == prev.l && cur_mu == prev.u))
                stall_viol++;
        end
        prev_stall = cur_mv && !m_ready && !abort && rst_n;
        prev = beat_t'{cur_md, cur_ml, cur_mu};
    end

    task automatic send_beat(input logic [31:0] d, input logic l, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = cur_sr;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        at = cyc;
        chk("accept_in_time", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = !cur_busy && !cur_mv;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("drain_in_time", 32'(ok), 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        int          at;
        logic [31:0] c;
        sel_rx = v.rx;
        bp_mode = v.bp;
        q.delete();
        err_cnt = 0;
        for (int i = 0; i < v.n; i++) frm[i] = $urandom;
        if (v.d0 != 32'h0) begin
            frm[0] = v.d0;
            frm[1] = v.d1;
        end
        if (v.rx) frm[v.n - 1] = model_crc(v.n - 1) ^ {31'h0, v.bad};
        c = model_crc(v.n);
        for (int i = 0; i < v.n; i++) send_beat(frm[i], 1'(i == v.n - 1), at);
        wait_idle();
        chk("beat_count", 32'(q.size()), 32'(v.beats));
        if (q.size() == v.beats) begin
            if (!v.rx) begin
                for (int i = 0; i < v.n; i++) begin
                    chk("tx_data", q[i].d, frm[i]);
                    chk("tx_last", 32'(q[i].l), 32'd0);
                end
                chk("tx_crc", q[v.n].d, c);
                chk("tx_crc_last", 32'(q[v.n].l), 32'd1);
                chk("tx_user", 32'(q[v.n].u), 32'd0);
            end else begin
                for (int i = 0; i < v.n - 1; i++) begin
                    chk("rx_data", q[i].d, frm[i]);
                    chk("rx_last", 32'(q[i].l), 32'(i == v.n - 2));
                    chk("rx_user", 32'(q[i].u), 32'((i == v.n - 2) && v.err));
                end
            end
        end
        chk("crc_err_pulses", 32'(err_cnt), 32'(v.rx && v.err));
    endtask

    task automatic do_abort(input bit rx);
        int at;
        vec_t v;
        sel_rx = rx;
        bp_mode = 0;
        @(posedge clk);
        #3;
        q.delete();
        err_cnt = 0;
        send_beat($urandom, 1'b0, at);
        send_beat($urandom, 1'b0, at);
        bp_mode = 3;
        s_valid = 1'b1;
        s_data = $urandom;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_tready", 32'(cur_sr), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_tvalid", 32'(cur_mv), 32'd0);
        chk("abort_tdata", cur_md, 32'h0);
        chk("abort_tlast", 32'(cur_ml), 32'd0);
        chk("abort_busy", 32'(cur_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_err", 32'(err_cnt), 32'd0);
        v = '{rx, rx ? 2 : 1, 1'b0, 0, 32'h0, 32'h0, rx ? 1 : 2, 1'b0};
        run_frame(v);
    endtask

    initial begin
        int          t1, t2;
        logic [31:0] a, b, ca, cb;
        vec_t        v;
        tbl[0] = '{1'b0, 2, 1'b0, 0, 32'h1111_1111, 32'h2222_2222, 3, 1'b0};
        tbl[1] = '{1'b0, 4, 1'b0, 1, 32'h0, 32'h0, 5, 1'b0};
        tbl[2] = '{1'b1, 3, 1'b0, 0, 32'hDEAD_BEEF, 32'h0123_4567, 2, 1'b0};
        tbl[3] = '{1'b1, 3, 1'b1, 0, 32'hDEAD_BEEF, 32'h0123_4567, 2, 1'b1};
        tbl[4] = '{1'b1, 1, 1'b0, 0, 32'h0, 32'h0, 0, 1'b1};
        tbl[5] = '{1'b0, 1, 1'b0, 2, 32'h0, 32'h0, 2, 1'b0};
        tbl[6] = '{1'b1, 5, 1'b0, 1, 32'h0, 32'h0, 4, 1'b0};
        tbl[7] = '{1'b1, 4, 1'b1, 2, 32'h0, 32'h0, 3, 1'b1};

        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_tvalid", 32'(tx_mv), 32'd0);
        chk("rst_tx_tready", 32'(tx_sr), 32'd0);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_tx_tdata", tx_md, 32'h0);
        chk("rst_rx_tvalid", 32'(rx_mv), 32'd0);
        chk("rst_rx_tready", 32'(rx_sr), 32'd0);
        chk("rst_rx_err", 32'(rx_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_frame(tbl[i]);

        for (int i = 0; i < 16; i++) begin
            v.rx    = 1'($urandom_range(0, 1));
            v.n     = $urandom_range(1, 6);
            v.bad   = v.rx && 1'($urandom_range(0, 1));
            v.bp    = $urandom_range(0, 2);
            v.d0    = 32'h0;
            v.d1    = 32'h0;
            v.beats = v.rx ? v.n - 1 : v.n + 1;
            v.err   = v.rx && (v.bad || v.n == 1);
            run_frame(v);
        end

        sel_rx = 1'b0;
        bp_mode = 0;
        q.delete();
        a = $urandom;
        b = $urandom;
        frm[0] = a;
        ca = model_crc(1);
        frm[0] = b;
        cb = model_crc(1);
        send_beat(a, 1'b1, t1);
        send_beat(b, 1'b1, t2);
        chk("b2b_accept_gap", 32'(t2 - t1), 32'd2);
        wait_idle();
        chk("b2b_count", 32'(q.size()), 32'd4);
        if (q.size() == 4) begin
            chk("b2b_a", q[0].d, a);
            chk("b2b_crc_a", q[1].d, ca);
            chk("b2b_b", q[2].d, b);
            chk("b2b_crc_b", q[3].d, cb);
        end

        do_abort(1'b0);
        do_abort(1'b1);

        sel_rx = 1'b0;
        bp_mode = 3;
        @(posedge clk);
        #3;
        send_beat($urandom, 1'b1, t1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tvalid", 32'(tx_mv), 32'd0);
        chk("arst_tdata", tx_md, 32'h0);
        chk("arst_tlast", 32'(tx_ml), 32'd0);
        chk("arst_busy", 32'(tx_busy), 32'd0);
        chk("arst_tready", 32'(tx_sr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{1'b0, 3, 1'b0, 0, 32'h0, 32'h0, 4, 1'b0};
        run_frame(v);

        chk("lowpower_idle_zero", 32'(lp_viol), 32'd0);
        chk("stall_stable", 32'(stall_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
